lsu_arbiter: RTL

Two-port arbiter and sequencer that shares the single load/store unit between the pipeline MEM stage (port 0) and a secondary bus master such as a DMA or program loader (port 1). It accepts one transaction at a time with a req/gnt handshake and registers the winning request onto the LSU inputs. It holds those inputs stable for the LSU's read latency, captures load data and returns a one-cycle response to the owning port. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

---
 rtl/lsu_arb_pkg.sv | 19 +
 rtl/lsu_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and limits for the two-port LSU arbiter.
package lsu_arb_pkg;

  localparam int unsigned ARB_RD_LAT_MAX = 3;
  localparam int unsigned ARB_STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } arb_port_e;

endpackage

// File: rtl/lsu_arbiter.sv
// Shares one LSU between the MEM stage (port 0) and an aux master (port 1);
// one transaction in flight, port 0 priority with starvation override.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic        i_p0_wren,
  input  logic [2:0]  i_p0_bmask,
  output logic        o_p0_gnt,
  output logic        o_p0_rsp_valid,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic        i_p1_wren,
  input  logic [2:0]  i_p1_bmask,
  output logic        o_p1_gnt,
  output logic        o_p1_rsp_valid,
  output logic [31:0] o_p1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_bmask,
  input  logic [31:0] i_ld_data
);

  localparam int unsigned WCNT_W = $clog2(ARB_RD_LAT_MAX + 1);
  localparam logic [WCNT_W-1:0] LP_WCNT_INIT =
    (RD_LAT == 0) ? '0 : WCNT_W'(RD_LAT - 1);
  localparam logic [ARB_STARVE_W-1:0] LP_STARVE_MAX = ARB_STARVE_W'(STARVE_MAX);

  arb_state_e              r_state;
  arb_state_e              w_next;
  arb_port_e               r_owner;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_wren;
  logic [2:0]              r_bmask;
  logic [31:0]             r_rdata;
  logic [WCNT_W-1:0]       r_wcnt;
  logic [ARB_STARVE_W-1:0] r_starve;

  logic w_force1;
  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_sample;
  logic w_resp;

  // Gating with i_reset keeps both grants low while reset is held.
  assign w_force1 = (r_starve == LP_STARVE_MAX);
  assign w_idle   = (r_state == IDLE) & i_reset;
  assign w_gnt0   = w_idle & i_p0_req & ~w_force1;
  assign w_gnt1   = w_idle & i_p1_req & (~i_p0_req | w_force1);
  assign w_sample = ((r_state == ISSUE) & ~r_wren & (RD_LAT == 0)) |
                    ((r_state == WAIT) & (r_wcnt == '0));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt0 | w_gnt1) w_next = ISSUE;
      ISSUE:   w_next = (r_wren || RD_LAT == 0) ? RESP : WAIT;
      WAIT:    if (r_wcnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_owner  <= PORT_CORE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wren   <= 1'b0;
      r_bmask  <= '0;
      r_rdata  <= '0;
      r_wcnt   <= '0;
      r_starve <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt1) begin
        r_owner <= PORT_AUX;
        r_addr  <= i_p1_addr;
        r_wdata <= i_p1_wdata;
        r_wren  <= i_p1_wren;
        r_bmask <= i_p1_bmask;
      end else if (w_gnt0) begin
        r_owner <= PORT_CORE;
        r_addr  <= i_p0_addr;
        r_wdata <= i_p0_wdata;
        r_wren  <= i_p0_wren;
        r_bmask <= i_p0_bmask;
      end
      if (w_gnt0 && i_p1_req) begin
        if (r_starve != LP_STARVE_MAX) r_starve <= r_starve + 1'b1;
      end else if (w_gnt0 || w_gnt1) begin
        r_starve <= '0;
      end
      if (r_state == ISSUE) r_wcnt <= LP_WCNT_INIT;
      else if (r_state == WAIT && r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
      if (w_sample) r_rdata <= i_ld_data;
    end
  end

  assign w_resp         = (r_state == RESP);
  assign o_p0_gnt       = w_gnt0;
  assign o_p1_gnt       = w_gnt1;
  assign o_p0_rsp_valid = w_resp & (r_owner == PORT_CORE);
  assign o_p1_rsp_valid = w_resp & (r_owner == PORT_AUX);
  assign o_p0_rdata     = (o_p0_rsp_valid & ~r_wren) ? r_rdata : '0;
  assign o_p1_rdata     = (o_p1_rsp_valid & ~r_wren) ? r_rdata : '0;
  assign o_lsu_addr     = r_addr;
  assign o_st_data      = r_wdata;
  assign o_bmask        = r_bmask;
  assign o_lsu_wren     = (r_state == ISSUE) & r_wren;

endmodule
